// File: rtl/reg_file_bank.sv
// reg_file_bank: multi-ported architectural register file with a post-reset
// clear sweep. Two combinational read ports with write-first bypass, one
// synchronous write port, and register 0 hard-wired to zero.
module reg_file_bank #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int SP_IDX  = 29,
    parameter int SP_INIT = 252
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREG)-1:0]  rs1,
    input  logic [$clog2(NREG)-1:0]  rs2,
    input  logic [$clog2(NREG)-1:0]  rd,
    input  logic                     wr_en,
    input  logic [XLEN-1:0]          wr_data,
    output logic [XLEN-1:0]          out_rs1,
    output logic [XLEN-1:0]          out_rs2,
    output logic                     busy
);

    localparam int AW = $clog2(NREG);

    // One extra bit so that NREG itself is representable (NREG = 2**AW case).
    localparam logic [AW:0]     NREG_W    = (AW + 1)'(NREG);
    localparam logic [AW-1:0]   LAST_IDX  = AW'(NREG - 1);
    localparam logic [AW-1:0]   SP_IDX_W  = AW'(SP_IDX);
    localparam bit              SP_VALID  = (SP_IDX >= 0) && (SP_IDX < NREG);
    localparam logic [XLEN-1:0] SP_VALUE  = XLEN'(SP_INIT);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   clr_cnt;
    logic [AW-1:0]   clr_cnt_next;
    logic [XLEN-1:0] clr_value;
    logic            rd_valid;
    logic            user_we;
    logic [XLEN-1:0] regs [NREG];

    // Sweep/ready sequencing: next state, next counter and the busy flag.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_next   = state;
        clr_cnt_next = clr_cnt;
        busy         = 1'b0;
        clr_value    = '0;
        case (state)
            CLEAR: begin
                busy         = 1'b1;
                clr_value    = (SP_VALID && (clr_cnt == SP_IDX_W)) ? SP_VALUE : '0;
                clr_cnt_next = clr_cnt + AW'(1);
                if (clr_cnt == LAST_IDX) begin
                    state_next = READY;
                end
            end
            READY: begin
                // Counter is no longer needed and simply holds.
                clr_cnt_next = clr_cnt;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // State register and sweep counter; reset restarts the sweep at index 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // A user write lands only when ready, for a real (non-zero, in-range) register.
    always_comb begin
        rd_valid = ({1'b0, rd} < NREG_W);
        user_we  = (state == READY) && wr_en && (rd != '0) && rd_valid;
    end

    // Register array storage: sweep writes during CLEAR, user writes during READY.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; its contents are defined by the sweep instead.
        if (!rst) begin
            if (state == CLEAR) begin
                regs[clr_cnt] <= clr_value;
            end else if (user_we) begin
                regs[rd] <= wr_data;
            end
        end
    end

    // Read port 1: zero for x0, out-of-range or busy; bypass a same-cycle write.
    always_comb begin
        out_rs1 = '0;
        if (!busy && (rs1 != '0) && ({1'b0, rs1} < NREG_W)) begin
            if (user_we && (rd == rs1)) begin
                out_rs1 = wr_data;
            end else begin
                out_rs1 = regs[rs1];
            end
        end
    end

    // Read port 2: same rules as port 1, evaluated independently.
    always_comb begin
        out_rs2 = '0;
        if (!busy && (rs2 != '0) && ({1'b0, rs2} < NREG_W)) begin
            if (user_we && (rd == rs2)) begin
                out_rs2 = wr_data;
            end else begin
                out_rs2 = regs[rs2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_bank.sv
// tb_reg_file_bank: drives a default bank (NREG=32) and a non-power-of-two
// bank (NREG=24) with the same directed stimulus. A register-level model of
// the architectural state is compared against both on every falling edge,
// and hand-computed literals pin the key scenarios.
module tb_reg_file_bank;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wr_en;
    logic [31:0] wr_data;

    logic [31:0] a_rs1, a_rs2, b_rs1, b_rs2;
    logic        a_busy, b_busy;

    int checks = 0;
    int errors = 0;

    reg_file_bank dut_a (
        .clk     (clk),
        .rst     (rst),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .out_rs1 (a_rs1),
        .out_rs2 (a_rs2),
        .busy    (a_busy)
    );

    reg_file_bank #(
        .XLEN    (32),
        .NREG    (24),
        .SP_IDX  (20),
        .SP_INIT (100)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .out_rs1 (b_rs1),
        .out_rs2 (b_rs2),
        .busy    (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per bank: how many busy cycles remain, and the architectural contents.
    int          m_nreg [2]  = '{32, 24};
    int          m_sp    [2] = '{29, 20};
    logic [31:0] m_spv   [2] = '{32'd252, 32'd100};
    int          m_left  [2];
    logic [31:0] m_regs  [2][32];
    bit          m_known = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_left[k] <= m_nreg[k];
                for (int r = 0; r < 32; r++)
                    m_regs[k][r] <= (r == m_sp[k]) ? m_spv[k] : 32'd0;
            end else if (m_left[k] > 0) begin
                m_left[k] <= m_left[k] - 1;
            end else if (wr_en && rd != 0 && int'(rd) < m_nreg[k]) begin
                m_regs[k][rd] <= wr_data;
            end
        end
        if (rst) m_known <= 1'b1;
    end

    function automatic logic [31:0] exp_read(input int k, input logic [4:0] rs);
        if (m_left[k] > 0 || rs == 0 || int'(rs) >= m_nreg[k]) return 32'd0;
        if (wr_en && rd == rs) return wr_data;
        return m_regs[k][rs];
    endfunction

    // Compare process: every falling edge once the model state is known.
    always @(negedge clk) begin
        if (m_known) begin
            check("a_busy", {31'd0, a_busy}, {31'd0, m_left[0] > 0});
            check("b_busy", {31'd0, b_busy}, {31'd0, m_left[1] > 0});
            check("a_rs1", a_rs1, exp_read(0, rs1));
            check("a_rs2", a_rs2, exp_read(0, rs2));
            check("b_rs1", b_rs1, exp_read(1, rs1));
            check("b_rs2", b_rs2, exp_read(1, rs2));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts busy falling edges for both banks over a fixed window; write
    // request stays asserted for the first n_wr cycles only.
    task automatic count_busy(input int n_wr, output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int i = 0; i < 60; i++) begin
            if (i >= n_wr) wr_en = 1'b0;
            @(negedge clk);
            ca += int'(a_busy);
            cb += int'(b_busy);
            tick();
        end
    endtask

    int ca, cb;

    initial begin
        rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; wr_en = 1'b0; wr_data = '0;
        tick();
        tick();

        // Held reset: busy and zero outputs.
        @(negedge clk);
        check("rst_busy", {31'd0, a_busy}, 32'd1);
        check("rst_out", a_rs1, 32'd0);
        tick();

        // Sweep length after a short reset.
        rst = 1'b0;
        count_busy(0, ca, cb);
        check("sweep_len_32", ca, 32'd32);
        check("sweep_len_24", cb, 32'd24);

        // Stack-pointer preset and an ordinary cleared register.
        rs1 = 5'd29; rs2 = 5'd5;
        @(negedge clk);
        check("sp_a", a_rs1, 32'd252);
        check("r5_a", a_rs2, 32'd0);
        tick();
        rs1 = 5'd20;
        @(negedge clk);
        check("sp_b", b_rs1, 32'd100);
        tick();

        // Write-first bypass, then the stored value.
        wr_en = 1'b1; rd = 5'd7; wr_data = 32'hDEADBEEF; rs1 = 5'd7;
        @(negedge clk);
        check("bypass_r7", a_rs1, 32'hDEADBEEF);
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        check("stored_r7", a_rs1, 32'hDEADBEEF);
        tick();

        // Writes to x0 neither bypass nor stick.
        wr_en = 1'b1; rd = 5'd0; wr_data = 32'hFFFFFFFF; rs1 = 5'd0; rs2 = 5'd7;
        @(negedge clk);
        check("x0_write_cycle", a_rs1, 32'd0);
        check("r7_unchanged", a_rs2, 32'hDEADBEEF);
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        check("x0_after", a_rs1, 32'd0);
        tick();

        // Same index on both read ports and the write port.
        wr_en = 1'b1; rd = 5'd12; wr_data = 32'h1234; rs1 = 5'd12; rs2 = 5'd12;
        @(negedge clk);
        check("dual_bypass_1", a_rs1, 32'h1234);
        check("dual_bypass_2", a_rs2, 32'h1234);
        tick();

        // Out-of-range index on the 24-entry bank.
        rd = 5'd30; wr_data = 32'h55; rs1 = 5'd30;
        @(negedge clk);
        check("oor_read_b", b_rs1, 32'd0);
        check("oor_bypass_a", a_rs1, 32'h55);
        tick();
        rd = 5'd3; wr_data = 32'h33;
        tick();
        wr_en = 1'b0;

        // Assorted writes, then walk every index on both ports.
        for (int i = 1; i < 32; i += 3) begin
            wr_en = 1'b1; rd = 5'(i); wr_data = 32'h01010101 * i; rs1 = 5'(i); rs2 = 5'(31 - i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            tick();
        end
        rs1 = 5'd30;
        @(negedge clk);
        check("oor_after_b", b_rs1, 32'd0);
        tick();

        // Reset mid-sweep with a write pending: sweep restarts and wins.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_en = 1'b1; rd = 5'd3; wr_data = 32'hAAAA;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        count_busy(20, ca, cb);
        check("restart_len_32", ca, 32'd32);
        check("restart_len_24", cb, 32'd24);
        rs1 = 5'd3; rs2 = 5'd12;
        @(negedge clk);
        check("r3_cleared_a", a_rs1, 32'd0);
        check("r3_cleared_b", b_rs1, 32'd0);
        check("r12_cleared_a", a_rs2, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_bank.md
REG_FILE_BANK -- requirements
Module: reg_file_bank

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width in bits.
REQ-002 SHALL have parameter NREG, default 32: number of architectural registers, 2..256.
REQ-003 SHALL have parameter SP_IDX, default 29: index of the register loaded with SP_INIT by the clear sweep.
REQ-004 SHALL have parameter SP_INIT, default 252: value written to register SP_IDX during the clear sweep.
REQ-005 SHALL derive localparam AW = clog2(NREG) as the index width.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port rs1, input, AW bits: read port 1 index.
REQ-009 SHALL have port rs2, input, AW bits: read port 2 index.
REQ-010 SHALL have port rd, input, AW bits: write index.
REQ-011 SHALL have port wr_en, input, 1 bit: write request.
REQ-012 SHALL have port wr_data, input, XLEN bits: write data.
REQ-013 SHALL have port out_rs1, output, XLEN bits: read data, port 1.
REQ-014 SHALL have port out_rs2, output, XLEN bits: read data, port 2.
REQ-015 SHALL have port busy, output, 1 bit: clear sweep in progress; the bank is unavailable.

Function
REQ-016 SHALL implement a two-state FSM, CLEAR and READY, plus an AW-bit sweep counter clr_cnt.
REQ-017 SHALL, on any edge with rst=1, enter CLEAR with clr_cnt=0, regardless of current state (reset mid-sweep restarts the sweep at index 0).
REQ-018 SHALL, in CLEAR with rst=0, write each edge to register clr_cnt: SP_INIT (truncated to XLEN) if clr_cnt==SP_IDX, else 0; then increment clr_cnt.
REQ-019 SHALL transition CLEAR->READY on the edge where clr_cnt==NREG-1 is written, so busy=1 for exactly NREG cycles after rst deasserts.
REQ-020 SHALL drive busy=1 combinationally in CLEAR and busy=0 in READY.
REQ-021 SHALL ignore wr_en in CLEAR; no user write lands during the sweep.
REQ-022 SHALL, in READY with wr_en=1, rd!=0 and rd<NREG, write wr_data to register rd on the rising edge.
REQ-023 SHALL never modify register 0 through the user port; register 0 reads as 0 at all times.
REQ-024 SHALL silently drop writes with rd>=NREG (NREG not a power of two).
REQ-025 SHALL make reads combinational: out_rsN = reg[rsN] in the same cycle.
REQ-026 SHALL return 0 on out_rsN when rsN==0, rsN>=NREG, or busy=1.
REQ-027 SHALL bypass writes: in READY, if wr_en=1, rd!=0, rd<NREG and rd==rsN, out_rsN = wr_data in the same cycle (write-first).
REQ-028 SHALL apply the bypass independently to both ports; rs1==rs2==rd returns wr_data on both.
REQ-029 SHALL not need clr_cnt wrap-around: the counter stops being used in READY and holds its value.

Reset
REQ-030 SHALL give every output a defined value in the cycle after an rst edge: busy=1, out_rs1=0, out_rs2=0.
REQ-031 SHALL leave register contents undefined until the sweep completes; only post-sweep values are architectural.
REQ-032 SHALL, when rst is held high for multiple cycles, keep the FSM in CLEAR with clr_cnt=0, leaving the sweep stalled at index 0.

Verification
REQ-033 SHALL cover: rst pulse 1 cycle, default params -> busy=1 for exactly 32 cycles; then reading rs1=29 gives 252 and rs2=5 gives 0.
REQ-034 SHALL cover: READY, wr_en=1, rd=7, wr_data=0xDEADBEEF, rs1=7 same cycle -> out_rs1=0xDEADBEEF (bypass); next cycle with wr_en=0 -> still 0xDEADBEEF.
REQ-035 SHALL cover: READY, wr_en=1, rd=0, wr_data=0xFFFFFFFF; next cycle rs1=0 -> out_rs1=0, including the write cycle itself (no bypass on x0).
REQ-036 SHALL cover: rst at sweep cycle 10, wr_en=1 rd=3 during the sweep -> busy stays 1 for 32 further cycles after rst drops; reg3=0 afterwards.
REQ-037 SHALL cover: NREG=24, rd=30 write of 0x55 -> no register changes; rs1=30 reads 0; busy lasts 24 cycles after reset.
REQ-038 SHALL cover: rs1=rs2=rd=12, wr_en=1, wr_data=0x1234 -> out_rs1=out_rs2=0x1234 the same cycle.
